// File: rtl/video_pkg.sv
// Shared raster geometry defaults, scan-out pipeline latency and coordinate widths
// for the video timing path.
package video_pkg;

  localparam int unsigned DEF_H_ACTIVE = 320;
  localparam int unsigned DEF_H_FRONT  = 16;
  localparam int unsigned DEF_H_SYNC   = 32;
  localparam int unsigned DEF_H_BACK   = 32;
  localparam int unsigned DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;

  localparam int unsigned DEF_V_ACTIVE = 192;
  localparam int unsigned DEF_V_FRONT  = 24;
  localparam int unsigned DEF_V_SYNC   = 3;
  localparam int unsigned DEF_V_BACK   = 43;
  localparam int unsigned DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  // Pixel latency of the downstream scan-out stage; syncs are delayed to match it.
  localparam int unsigned SCANOUT_LATENCY = 2;

  localparam int unsigned X_W   = 9;
  localparam int unsigned Y_W   = 8;
  localparam int unsigned CNT_W = 9;

  typedef struct packed {
    logic vsync;
    logic hsync;
  } sync_pair_t;

endpackage

// File: rtl/video_timing_if.sv
// Raster output bundle from the timing generator to the scan-out stage; the frame
// flag handshake exists only with VIDEO_TIMING_FRAME_IRQ_EN.
interface video_timing_if;
  import video_pkg::*;

  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic           visible;
  logic           hsync;
  logic           vsync;
  logic           lineStart;
  logic           frameStart;
`ifdef VIDEO_TIMING_FRAME_IRQ_EN
  logic           irqAck;
  logic           frameIrq;
`endif

  modport master (
    output x, y, visible, hsync, vsync, lineStart, frameStart
`ifdef VIDEO_TIMING_FRAME_IRQ_EN
    , input irqAck, output frameIrq
`endif
  );

  modport slave (
    input x, y, visible, hsync, vsync, lineStart, frameStart
`ifdef VIDEO_TIMING_FRAME_IRQ_EN
    , output irqAck, input frameIrq
`endif
  );

endinterface

// File: rtl/sync_delay.sv
// N-stage shift register for a {vsync, hsync} pair; synchronous reset fills every
// stage with RST_VAL. N == 0 is a plain wire.
module sync_delay #(
  parameter int unsigned N       = 2,
  parameter logic [1:0]  RST_VAL = 2'b00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] d_i,
  output logic [1:0] q_o
);

  if (N == 0) begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign q_o = d_i;
  end else begin : g_shift
    localparam int unsigned W = 2 * N;
    logic [W-1:0] sr_q;

    // Newest sample enters at the bottom, oldest leaves from the top.
    always_ff @(posedge clk) begin
      if (rst) begin
        sr_q <= {N{RST_VAL}};
      end else begin
        sr_q <= (sr_q << 2) | W'(d_i);
      end
    end

    assign q_o = sr_q[W-1 -: 2];
  end

endmodule

// File: rtl/video_timing.sv
// Raster timing generator: coordinates, visible qualifier, line/frame pulses and
// scan-out-aligned syncs. VIDEO_TIMING_FRAME_IRQ_EN adds a sticky vblank flag.
module video_timing
  import video_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
  parameter int unsigned H_FRONT    = DEF_H_FRONT,
  parameter int unsigned H_SYNC     = DEF_H_SYNC,
  parameter int unsigned H_BACK     = DEF_H_BACK,
  parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
  parameter int unsigned V_FRONT    = DEF_V_FRONT,
  parameter int unsigned V_SYNC     = DEF_V_SYNC,
  parameter int unsigned V_BACK     = DEF_V_BACK,
  parameter int unsigned SYNC_DELAY = SCANOUT_LATENCY,
  parameter bit          SYNC_POL   = 1'b0
) (
  input  logic           vClk,
  input  logic           vReset,
  video_timing_if.master vid
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HS_START = H_ACTIVE + H_FRONT;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FRONT;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  if ((H_TOTAL > 512) || (V_TOTAL > 512) || (V_ACTIVE > 256)) begin : g_geom_check
    $error("video_timing: geometry does not fit the 9-bit counters / 8-bit y");
  end

  logic [CNT_W-1:0] h_q, h_d;
  logic [CNT_W-1:0] v_q, v_d;
  logic             run_q;
  logic [Y_W-1:0]   y_q, y_d;
  logic             visible_q, visible_d;
  logic             line_start_q, line_start_d;
  logic             frame_start_q, frame_start_d;
  logic             line_act;
  sync_pair_t       sync_raw_q, sync_raw_d;
  sync_pair_t       sync_dly;

  // First clock out of reset presents (0,0) instead of advancing past it.
  always_comb begin
    h_d = '0;
    v_d = '0;
    if (run_q) begin
      if (h_q == CNT_W'(H_TOTAL - 1)) begin
        v_d = (v_q == CNT_W'(V_TOTAL - 1)) ? '0 : v_q + CNT_W'(1);
      end else begin
        h_d = h_q + CNT_W'(1);
        v_d = v_q;
      end
    end
  end

  // Decode the next position so every output lines up with the counter it describes.
  always_comb begin
    line_act         = (v_d < CNT_W'(V_ACTIVE));
    visible_d        = line_act && (h_d < CNT_W'(H_ACTIVE));
    y_d              = line_act ? v_d[Y_W-1:0] : '0;
    line_start_d     = (h_d == '0);
    frame_start_d    = line_start_d && (v_d == '0);
    sync_raw_d.hsync = (h_d >= CNT_W'(HS_START)) && (h_d < CNT_W'(HS_END));
    sync_raw_d.vsync = (v_d >= CNT_W'(VS_START)) && (v_d < CNT_W'(VS_END));
  end

  always_ff @(posedge vClk) begin
    if (vReset) begin
      h_q           <= '0;
      v_q           <= '0;
      run_q         <= 1'b0;
      y_q           <= '0;
      visible_q     <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      sync_raw_q    <= '0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      run_q         <= 1'b1;
      y_q           <= y_d;
      visible_q     <= visible_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      sync_raw_q    <= sync_raw_d;
    end
  end

  sync_delay #(
    .N       (SYNC_DELAY),
    .RST_VAL (2'b00)
  ) u_sync_delay (
    .clk (vClk),
    .rst (vReset),
    .d_i (sync_raw_q),
    .q_o (sync_dly)
  );

  assign vid.x          = X_W'(h_q);
  assign vid.y          = y_q;
  assign vid.visible    = visible_q;
  assign vid.lineStart  = line_start_q;
  assign vid.frameStart = frame_start_q;
  assign vid.hsync      = SYNC_POL ? sync_dly.hsync : ~sync_dly.hsync;
  assign vid.vsync      = SYNC_POL ? sync_dly.vsync : ~sync_dly.vsync;

`ifdef VIDEO_TIMING_FRAME_IRQ_EN
  logic frame_irq_q, frame_irq_d;

  // Start of vblank sets the flag; an ack in the same cycle loses to the set.
  always_comb begin
    frame_irq_d = frame_irq_q;
    if (vid.irqAck) begin
      frame_irq_d = 1'b0;
    end
    if ((h_d == '0) && (v_d == CNT_W'(V_ACTIVE))) begin
      frame_irq_d = 1'b1;
    end
  end

  always_ff @(posedge vClk) begin
    if (vReset) begin
      frame_irq_q <= 1'b0;
    end else begin
      frame_irq_q <= frame_irq_d;
    end
  end

  assign vid.frameIrq = frame_irq_q;
`endif

endmodule

// File: tb/tb_video_timing.sv
// Bench for video_timing: a default-geometry instance and a small-geometry instance
// (3-stage delay, active-high syncs) checked every cycle against a raster model.
module tb_video_timing;
  import video_pkg::*;

  typedef struct {
    int unsigned ha, hf, hs, hb, va, vf, vs, vb, dly;
    bit          pol;
  } geom_t;

  typedef struct {
    int unsigned t;
    logic [8:0]  x;
    logic [7:0]  y;
    logic        vis, ls, fs, hs, vs;
  } vec_t;

  logic vClk;
  logic vReset;
  logic irq_ack;

  int unsigned total;
  int unsigned bad;
  int          since_rel;

  geom_t       g[2];
  bit          m_rst[2];
  int unsigned m_t[2];
  bit          m_irq[2];
  vec_t        vec[13];

  video_timing_if vid_a ();
  video_timing_if vid_b ();

`ifdef VIDEO_TIMING_FRAME_IRQ_EN
  assign vid_a.irqAck = irq_ack;
  assign vid_b.irqAck = irq_ack;
`endif

  video_timing u_dut_a (
    .vClk   (vClk),
    .vReset (vReset),
    .vid    (vid_a.master)
  );

  video_timing #(
    .H_ACTIVE (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (3),
    .V_ACTIVE (5), .V_FRONT (1), .V_SYNC (2), .V_BACK (2),
    .SYNC_DELAY (3), .SYNC_POL (1'b1)
  ) u_dut_b (
    .vClk   (vClk),
    .vReset (vReset),
    .vid    (vid_b.master)
  );

  initial vClk = 1'b0;
  always #5 vClk = ~vClk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (time %0t, since_rel %0d)", name, got, exp, $time, since_rel);
    end
  endtask

  // Model state advances on each clock edge from the sampled reset/ack.
  function automatic void mdl_edge(input int k, input bit rst, input bit ack);
    int unsigned ht, vt, h, v;
    ht = g[k].ha + g[k].hf + g[k].hs + g[k].hb;
    vt = g[k].va + g[k].vf + g[k].vs + g[k].vb;
    if (rst) begin
      m_rst[k] = 1'b1;
      m_t[k]   = 0;
      m_irq[k] = 1'b0;
    end else begin
      if (m_rst[k]) begin
        m_rst[k] = 1'b0;
        m_t[k]   = 0;
      end else begin
        m_t[k]++;
      end
      h = m_t[k] % ht;
      v = (m_t[k] / ht) % vt;
      if (h == 0 && v == g[k].va) m_irq[k] = 1'b1;
      else if (ack) m_irq[k] = 1'b0;
    end
  endfunction

  // Expected {x, y, visible, lineStart, frameStart, hsync, vsync, frameIrq}.
  function automatic logic [22:0] mdl_exp(input int k);
    int unsigned ht, vt, h, v, s, sh, sv;
    logic rh, rv, vis, irq;
    ht  = g[k].ha + g[k].hf + g[k].hs + g[k].hb;
    vt  = g[k].va + g[k].vf + g[k].vs + g[k].vb;
    irq = 1'b0;
`ifdef VIDEO_TIMING_FRAME_IRQ_EN
    irq = m_irq[k];
`endif
    if (m_rst[k]) return {9'd0, 8'd0, 3'b000, ~g[k].pol, ~g[k].pol, irq};
    h  = m_t[k] % ht;
    v  = (m_t[k] / ht) % vt;
    rh = 1'b0;
    rv = 1'b0;
    if (m_t[k] >= g[k].dly) begin
      s  = m_t[k] - g[k].dly;
      sh = s % ht;
      sv = (s / ht) % vt;
      rh = (sh >= g[k].ha + g[k].hf) && (sh < g[k].ha + g[k].hf + g[k].hs);
      rv = (sv >= g[k].va + g[k].vf) && (sv < g[k].va + g[k].vf + g[k].vs);
    end
    vis = (h < g[k].ha) && (v < g[k].va);
    return {9'(h), (v < g[k].va) ? 8'(v) : 8'd0, vis, 1'(h == 0), 1'(h == 0 && v == 0),
            rh ~^ g[k].pol, rv ~^ g[k].pol, irq};
  endfunction

  function automatic logic [22:0] pack_a();
    logic irq;
    irq = 1'b0;
`ifdef VIDEO_TIMING_FRAME_IRQ_EN
    irq = vid_a.frameIrq;
`endif
    return {vid_a.x, vid_a.y, vid_a.visible, vid_a.lineStart, vid_a.frameStart,
            vid_a.hsync, vid_a.vsync, irq};
  endfunction

  function automatic logic [22:0] pack_b();
    logic irq;
    irq = 1'b0;
`ifdef VIDEO_TIMING_FRAME_IRQ_EN
    irq = vid_b.frameIrq;
`endif
    return {vid_b.x, vid_b.y, vid_b.visible, vid_b.lineStart, vid_b.frameStart,
            vid_b.hsync, vid_b.vsync, irq};
  endfunction

  task automatic step();
    @(posedge vClk);
    mdl_edge(0, vReset, irq_ack);
    mdl_edge(1, vReset, irq_ack);
    if (vReset) since_rel = -1;
    else since_rel++;
    #1;
    chk("cycle_a", 32'(pack_a()), 32'(mdl_exp(0)));
    chk("cycle_b", 32'(pack_b()), 32'(mdl_exp(1)));
  endtask

  initial begin
    int n;
    total     = 0;
    bad       = 0;
    since_rel = -1;
    vReset    = 1'b1;
    irq_ack   = 1'b0;
    g[0] = '{DEF_H_ACTIVE, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK,
             DEF_V_ACTIVE, DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK, SCANOUT_LATENCY, 1'b0};
    g[1] = '{8, 2, 3, 3, 5, 1, 2, 2, 3, 1'b1};
    for (int k = 0; k < 2; k++) begin
      m_rst[k] = 1'b1;
      m_t[k]   = 0;
      m_irq[k] = 1'b0;
    end

    // Default-geometry landmarks, counted in clocks since reset release.
    vec[0]  = '{0,   9'd0,   8'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    vec[1]  = '{1,   9'd1,   8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vec[2]  = '{319, 9'd319, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vec[3]  = '{320, 9'd320, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vec[4]  = '{336, 9'd336, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vec[5]  = '{337, 9'd337, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vec[6]  = '{338, 9'd338, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vec[7]  = '{369, 9'd369, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vec[8]  = '{370, 9'd370, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vec[9]  = '{399, 9'd399, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vec[10] = '{400, 9'd0,   8'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    vec[11] = '{401, 9'd1,   8'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vec[12] = '{800, 9'd0,   8'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    repeat (3) step();
    chk("rst_x",   32'(vid_a.x), 32'd0);
    chk("rst_y",   32'(vid_a.y), 32'd0);
    chk("rst_vis", 32'(vid_a.visible), 32'd0);
    chk("rst_fs",  32'(vid_a.frameStart), 32'd0);
    chk("rst_hs",  32'(vid_a.hsync), 32'd1);
    chk("rst_vs",  32'(vid_a.vsync), 32'd1);
    vReset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      while (since_rel < int'(vec[i].t)) step();
      chk($sformatf("vec%0d", i),
          32'({vid_a.x, vid_a.y, vid_a.visible, vid_a.lineStart, vid_a.frameStart, vid_a.hsync, vid_a.vsync}),
          32'({vec[i].x, vec[i].y, vec[i].vis, vec[i].ls, vec[i].fs, vec[i].hs, vec[i].vs}));
    end

    // hsync falling edge position and low width on line 2.
    n = 0;
    while (vid_a.hsync !== 1'b0 && n < 500) begin step(); n++; end
    chk("hs_fall_x", 32'(vid_a.x), 32'd338);
    n = 0;
    while (vid_a.hsync === 1'b0 && n < 100) begin n++; step(); end
    chk("hs_width", 32'(n), 32'd32);

    // One-cycle reset in the middle of line 77.
    n = 0;
    while (!(vid_a.x === 9'd150 && vid_a.y === 8'd77) && n < 40000) begin step(); n++; end
    chk("mid_reach", 32'({vid_a.x, vid_a.y}), 32'({9'd150, 8'd77}));
    vReset = 1'b1;
    step();
    chk("mid_rst_vis", 32'({vid_a.x, vid_a.y, vid_a.visible}), 32'd0);
    vReset = 1'b0;
    step();
    chk("mid_rel_pos", 32'({vid_a.x, vid_a.y}), 32'd0);
    chk("mid_rel_vis", 32'(vid_a.visible), 32'd1);
    chk("mid_rel_fs",  32'(vid_a.frameStart), 32'd1);
    chk("mid_rel_syn0", 32'({vid_a.hsync, vid_a.vsync}), 32'd3);
    step();
    chk("mid_rel_syn1", 32'({vid_a.hsync, vid_a.vsync}), 32'd3);
    chk("mid_rel_x1",   32'(vid_a.x), 32'd1);

`ifdef VIDEO_TIMING_FRAME_IRQ_EN
    // Small geometry: vblank starts 80 clocks into each 160-clock frame.
    n = 0;
    while (vid_b.frameIrq !== 1'b1 && n < 400) begin step(); n++; end
    chk("irq_rise_t", 32'(since_rel), 32'd80);
    repeat (10) step();
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    chk("irq_ack_clr", 32'(vid_b.frameIrq), 32'd0);
    n = 0;
    while (vid_b.frameIrq !== 1'b1 && n < 400) begin step(); n++; end
    chk("irq_rerise_t", 32'(since_rel), 32'd240);
    n = 0;
    while (since_rel < 399 && n < 400) begin step(); n++; end
    irq_ack = 1'b1;
    step();
    chk("irq_set_wins", 32'(vid_b.frameIrq), 32'd1);
    step();
    chk("irq_held_clr", 32'(vid_b.frameIrq), 32'd0);
    irq_ack = 1'b0;
`endif

    // Random run lengths, reset pulses and acks against the model.
    for (int seg = 0; seg < 25; seg++) begin
      repeat ($urandom_range(20, 500)) begin
        irq_ack = ($urandom_range(0, 7) == 0);
        step();
      end
      if ($urandom_range(0, 2) == 0) begin
        vReset = 1'b1;
        repeat ($urandom_range(1, 3)) step();
        vReset = 1'b0;
      end
    end
    irq_ack = 1'b0;
    repeat (200) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
